// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared helpers for the segmented add/sub pipeline
//
// Purpose: parameter arithmetic shared by the pipeline top and its segment adder.
// Ports: none (package).
package pipelined_addsub_pkg;

    // Width of one carry segment (bits added per pipeline stage).
    function automatic int unsigned seg_bits(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Legal configurations cut WIDTH into STAGES equal, non-empty segments.
    function automatic bit params_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/carry_segment_adder.sv
// rtl/carry_segment_adder.sv - combinational SEG-bit adder slice with carry in/out
//
// Purpose: one segment of the split carry chain; the top registers its carry-out.
// Ports:
//   a_i, b_i  SEG-bit operand segments (b_i already inverted for subtraction)
//   ci_i      carry into the segment's bit 0
//   s_o       SEG-bit segment sum
//   co_o      carry out of the segment's top bit
module carry_segment_adder
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           ci_i,
    output logic [SEG-1:0] s_o,
    output logic           co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, ci_i};

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined adder/subtractor with split carry chain
//
// Purpose: WIDTH-bit A+B+CI or A+~B+CI cut into STAGES segments, one segment
// per pipeline stage, with valid tracking, stall and flush. Latency STAGES.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i             a_i/b_i/sub_i/ci_i form an operation this cycle
//   a_i, b_i               WIDTH-bit operands
//   sub_i, ci_i            invert b_i / carry into bit 0
//   stall_i                hold every pipeline register, drop the input
//   flush_i                clear every stage valid bit (wins over stall_i)
//   out_valid_o            q_o/co_o/ovf_o belong to a completed operation
//   q_o, co_o, ovf_o       result, carry out, signed overflow
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             ci_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] q_o,
    output logic             co_o,
    output logic             ovf_o
);

    localparam int unsigned SEG  = seg_bits(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    // Inversion happens once at capture; sub_i is not carried down the pipe.
    logic [WIDTH-1:0] b_eff;
    assign b_eff = sub_i ? ~b_i : b_i;

    // Stage k adds segment k. Each stage keeps only what is still needed:
    // the not-yet-added upper operand segments (skew) and the already-summed
    // lower result segments (deskew), so register widths shrink/grow per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]       seg_a;
        logic [SEG-1:0]       seg_b;
        logic [SEG-1:0]       seg_s;
        logic                 c_in;
        logic                 c_d;
        logic                 v_d;
        logic [SEG*(k+1)-1:0] r_d;
        logic [SEG*(k+1)-1:0] r_q;
        logic                 c_q;
        logic                 v_q;

        if (k == 0) begin : g_in
            assign seg_a = a_i[SEG-1:0];
            assign seg_b = b_eff[SEG-1:0];
            assign c_in  = ci_i;
            assign v_d   = in_valid_i;
            assign r_d   = seg_s;
        end else begin : g_in
            assign seg_a = g_stage[k-1].g_ops.a_q[SEG-1:0];
            assign seg_b = g_stage[k-1].g_ops.b_q[SEG-1:0];
            assign c_in  = g_stage[k-1].c_q;
            assign v_d   = g_stage[k-1].v_q;
            assign r_d   = {seg_s, g_stage[k-1].r_q};
        end

        carry_segment_adder #(
            .SEG (SEG)
        ) u_seg (
            .a_i  (seg_a),
            .b_i  (seg_b),
            .ci_i (c_in),
            .s_o  (seg_s),
            .co_o (c_d)
        );

        // Data loads whenever not stalled, regardless of valid, so outputs
        // stay deterministic even for bubbles.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else begin
                if (!stall_i) begin
                    r_q <= r_d;
                    c_q <= c_d;
                end
                if (flush_i) begin
                    v_q <= 1'b0;
                end else if (!stall_i) begin
                    v_q <= v_d;
                end
            end
        end

        // Skew registers: upper operand segments still waiting for their stage.
        if (k < LAST) begin : g_ops
            localparam int unsigned UW = WIDTH - SEG * (k + 1);
            logic [UW-1:0] a_d;
            logic [UW-1:0] b_d;
            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;

            if (k == 0) begin : g_src
                assign a_d = a_i[WIDTH-1:SEG];
                assign b_d = b_eff[WIDTH-1:SEG];
            end else begin : g_src
                assign a_d = g_stage[k-1].g_ops.a_q[WIDTH-SEG*k-1:SEG];
                assign b_d = g_stage[k-1].g_ops.b_q[WIDTH-SEG*k-1:SEG];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall_i) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // The last stage sees the top segment, so it holds both operand sign
        // bits and the final sum sign needed for signed overflow.
        if (k == LAST) begin : g_ovf
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = (seg_a[SEG-1] == seg_b[SEG-1]) && (seg_s[SEG-1] != seg_a[SEG-1]);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ovf_q <= 1'b0;
                end else if (!stall_i) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid_o = g_stage[LAST].v_q;
    assign q_o         = g_stage[LAST].r_q;
    assign co_o        = g_stage[LAST].c_q;
    assign ovf_o       = g_stage[LAST].g_ovf.ovf_q;

endmodule
